// File: rtl/mod_msg_schedule.sv
// mod_msg_schedule -- SHA-256 message-schedule generator.
//
// Accepts one 512-bit block as 16 big-endian words (bit 0 = MSB) on a
// valid/ready input stream. It then emits W[0..ROUNDS-1] on a valid/ready
// output stream for the compression round engine.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   IN_WORD carries a message word
//   IN_READY   high while loading (LOAD state)
//   IN_WORD    message word [0:31], bit 0 = MSB
//   OUT_VALID  OUT_WORD holds W[t]
//   OUT_READY  downstream accepts OUT_WORD
//   OUT_WORD   schedule word W[t], bit 0 = MSB
//   OUT_LAST   high with OUT_VALID while t = ROUNDS-1
//   BUSY       high in EMIT state
//
// The file also holds the two small-sigma function blocks used by the
// expansion: mod_sigma0 and mod_sigma1.

// mod_sigma0 -- SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3.
// Ports: x (input word, bit 0 = MSB), y (result).
module mod_sigma0 (
  input  logic [0:31] x,
  output logic [0:31] y
);
  assign y = {x[25:31], x[0:24]} ^ {x[14:31], x[0:13]} ^ {3'b000, x[0:28]};
endmodule

// mod_sigma1 -- SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10.
// Ports: x (input word, bit 0 = MSB), y (result).
module mod_sigma1 (
  input  logic [0:31] x,
  output logic [0:31] y
);
  assign y = {x[15:31], x[0:14]} ^ {x[13:31], x[0:12]} ^ {10'b0, x[0:21]};
endmodule

module mod_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [0:31] IN_WORD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [0:31] OUT_WORD,
  output logic        OUT_LAST,
  output logic        BUSY
);

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_t      state;
  logic [3:0]  count;
  logic [6:0]  t;
  logic [0:31] win [16];
  logic [0:31] s0;
  logic [0:31] s1;
  logic [0:31] next_w;
  logic        accept;
  logic        xfer;

  // The window is kept one block ahead of the output register. While
  // OUT_WORD = W[t], win[i] = W[t+i]. This is the W[t'-16..t'-1] history
  // for t' = t+16, the next word to be generated. Loading shifts words in
  // at win[15]. After the 16th word, win[0..15] = W[0..15].
  mod_sigma0 u_sigma0 (.x(win[1]),  .y(s0));
  mod_sigma1 u_sigma1 (.x(win[14]), .y(s1));

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], mod 2^32
  assign next_w = s1 + win[9] + s0 + win[0];

  assign IN_READY = (state == LOAD);
  assign BUSY     = (state == EMIT);
  assign accept   = IN_VALID & IN_READY;
  assign xfer     = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= LOAD;
      count     <= '0;
      t         <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_WORD  <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= IN_WORD;
            count   <= count + 4'd1;
            // Last word: win[1] currently holds W[0].
            if (count == 4'd15) begin
              state     <= EMIT;
              t         <= '0;
              OUT_WORD  <= win[1];
              OUT_VALID <= 1'b1;
              OUT_LAST  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if (OUT_LAST) begin
              state     <= LOAD;
              count     <= '0;
              t         <= '0;
              OUT_VALID <= 1'b0;
              OUT_LAST  <= 1'b0;
            end else begin
              for (int i = 0; i < 15; i++) win[i] <= win[i+1];
              win[15]  <= next_w;
              t        <= t + 7'd1;
              OUT_WORD <= win[1];
              OUT_LAST <= ((t + 7'd1) == LAST_T);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_msg_schedule.sv
module tb_mod_msg_schedule;
  localparam int ROUNDS = 64;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [0:31] IN_WORD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [0:31] OUT_WORD;
  logic        OUT_LAST;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got   [64];

  mod_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_WORD(IN_WORD), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_WORD(OUT_WORD), .OUT_LAST(OUT_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_zero();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
  endtask

  task automatic build_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the 16th accept.
  task automatic load_block(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        IN_VALID = 1'b0;
        IN_WORD  = 32'hBAD00000;
        @(posedge CLK); #1;
      end
      if (i == 15) chk("ovalid_before_last", OUT_VALID, 1'b0);
      IN_VALID = 1'b1;
      IN_WORD  = blk[i];
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic run_emit(input bit stall, input bit hold_in, input int abort_at,
                          output int busy_cyc);
    int idx = 0;
    int stalled = 0;
    int cyc = 0;
    busy_cyc = 0;
    chk("ovalid_latency", OUT_VALID, 1'b1);
    if (hold_in) begin
      IN_VALID = 1'b1;
      IN_WORD  = 32'hFFFFFFFF;
    end
    OUT_READY = 1'b1;
    while (idx < ROUNDS && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (BUSY) busy_cyc++;
      if (OUT_READY && OUT_VALID) begin
        got[idx] = OUT_WORD;
        chk($sformatf("w%0d", idx), OUT_WORD, exp_w[idx]);
        chk($sformatf("last%0d", idx), OUT_LAST, (idx == ROUNDS - 1));
        chk($sformatf("iready_emit%0d", idx), IN_READY, 1'b0);
        idx++;
      end else if (!OUT_READY) begin
        chk("stall_word", OUT_WORD, exp_w[idx]);
        chk("stall_valid", OUT_VALID, 1'b1);
      end
      @(posedge CLK); #1;
      if (idx == abort_at) begin
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        #2;
        chk("abort_ovalid", OUT_VALID, 1'b0);
        chk("abort_olast", OUT_LAST, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_iready", IN_READY, 1'b1);
        chk("abort_oword", OUT_WORD, 32'h0);
        return;
      end
      if (stall && idx == 17 && stalled < 5) begin
        OUT_READY = 1'b0;
        stalled++;
      end else begin
        OUT_READY = 1'b1;
      end
    end
    IN_VALID = 1'b0;
    if (idx < ROUNDS) chk("emit_timeout", idx, ROUNDS);
    chk("ovalid_after", OUT_VALID, 1'b0);
    chk("iready_after", IN_READY, 1'b1);
    chk("busy_after", BUSY, 1'b0);
    chk("olast_after", OUT_LAST, 1'b0);
  endtask

  task automatic check_abc_words(input string tag);
    chk({tag, "_w0"},  got[0],  32'h61626380);
    chk({tag, "_w16"}, got[16], 32'h61626380);
    chk({tag, "_w17"}, got[17], 32'h000F0000);
    chk({tag, "_w18"}, got[18], 32'h7DA86405);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    RST_N = 1'b1; IN_VALID = 1'b0; IN_WORD = '0; OUT_READY = 1'b0;
    #2 RST_N = 1'b0;
    #2;
    chk("rst_iready", IN_READY, 1'b1);
    chk("rst_ovalid", OUT_VALID, 1'b0);
    chk("rst_olast", OUT_LAST, 1'b0);
    chk("rst_oword", OUT_WORD, 32'h0);
    chk("rst_busy", BUSY, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Test 1: partial block, reset mid-stream, then the "abc" block.
    for (int i = 0; i < 7; i++) begin
      IN_VALID = 1'b1;
      IN_WORD  = 32'h11110000 + i;
      @(posedge CLK); #1;
    end
    RST_N = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("midrst_iready", IN_READY, 1'b1);
    chk("midrst_ovalid", OUT_VALID, 1'b0);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    set_abc(); build_exp();
    load_block(1'b0);
    run_emit(1'b0, 1'b0, -1, b);
    check_abc_words("t1");

    // Test 2: all-zero block, BUSY duration.
    set_zero(); build_exp();
    load_block(1'b0);
    run_emit(1'b0, 1'b0, -1, b);
    chk("zero_w63", got[63], 32'h0);
    chk("zero_busy_cycles", b, 64);

    // Test 3: back-pressure while W17 is presented.
    set_abc(); build_exp();
    load_block(1'b0);
    run_emit(1'b1, 1'b0, -1, b);
    check_abc_words("t3");
    chk("t3_busy_cycles", b, 69);

    // Test 4: input gaps during LOAD, IN_VALID held during EMIT.
    load_block(1'b1);
    run_emit(1'b0, 1'b1, -1, b);
    check_abc_words("t4");

    // Test 5: reset at t=30, then reload.
    load_block(1'b0);
    run_emit(1'b0, 1'b0, 30, b);
    #1 RST_N = 1'b1;
    OUT_READY = 1'b0;
    @(posedge CLK); #1;
    load_block(1'b0);
    run_emit(1'b0, 1'b0, -1, b);
    check_abc_words("t5");

    // Test 6: two blocks back to back.
    load_block(1'b0);
    run_emit(1'b0, 1'b0, -1, b);
    check_abc_words("t6a");
    load_block(1'b0);
    run_emit(1'b0, 1'b0, -1, b);
    check_abc_words("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
